// File: rtl/keypad_pkg.sv
// Shared key codes and types for the keypad operand entry block.
// Digits 0..9 map directly to their key codes; 0xE/0xF are unused.
package keypad_pkg;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
    localparam logic [3:0] KEY_PLUS      = 4'hA;
    localparam logic [3:0] KEY_EQ        = 4'hB;
    localparam logic [3:0] KEY_CLR       = 4'hC;
    localparam logic [3:0] KEY_BACK      = 4'hD;

    typedef enum logic [1:0] {
        ST_A   = 2'd0,
        ST_B   = 2'd1,
        ST_RES = 2'd2
    } entry_state_t;

    typedef logic [3:0] bcd_t;

endpackage

// File: rtl/bcd_to_bin.sv
// Combinational conversion of a packed BCD digit array to binary.
// Index 0 is the least significant digit.
module bcd_to_bin
    import keypad_pkg::*;
#(
    parameter  int DIGITS = 3,
    localparam int OPW    = $clog2(10 ** DIGITS)
) (
    input  bcd_t [DIGITS-1:0] digits_i,
    output logic [OPW-1:0]    value_o
);

    // Horner evaluation from the most significant digit down
    always_comb begin
        value_o = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            value_o = value_o * OPW'(10) + OPW'(digits_i[i]);
        end
    end

endmodule

// File: rtl/keypad_operand_entry.sv
// Assembles decimal operands A and B from keypad strobes and produces A+B.
// All key effects appear one cycle after the key_valid strobe.
module keypad_operand_entry
    import keypad_pkg::*;
#(
    parameter  int DIGITS = 3,
    localparam int OPW    = $clog2(10 ** DIGITS)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     key_code,
    input  logic           key_valid,
    output logic [OPW-1:0] operand_a,
    output logic [OPW-1:0] operand_b,
    output logic [OPW:0]   sum,
    output logic           sum_valid,
    output logic [OPW:0]   disp_value,
    output logic [1:0]     state,
    output logic [1:0]     digit_count,
    output logic           key_reject
);

    entry_state_t      state_q;
    bcd_t [DIGITS-1:0] dig_a_q;
    bcd_t [DIGITS-1:0] dig_b_q;
    logic [1:0]        count_q;
    logic [OPW:0]      sum_q;
    logic              sum_valid_q;
    logic              reject_q;

    logic              is_digit;
    logic              room_left;

    assign is_digit  = (key_code <= KEY_DIGIT_MAX);
    assign room_left = (count_q < 2'(DIGITS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_A;
            dig_a_q     <= '0;
            dig_b_q     <= '0;
            count_q     <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            reject_q    <= 1'b0;
        end else begin
            sum_valid_q <= 1'b0;
            reject_q    <= 1'b0;
            if (key_valid && key_code == KEY_CLR) begin
                state_q <= ST_A;
                dig_a_q <= '0;
                dig_b_q <= '0;
                count_q <= '0;
                sum_q   <= '0;
            end else begin
                case (state_q)
                    ST_A, ST_B: begin
                        if (key_valid) begin
                            if (is_digit) begin
                                if (room_left) begin
                                    if (state_q == ST_A)
                                        dig_a_q <= {dig_a_q[DIGITS-2:0], key_code};
                                    else
                                        dig_b_q <= {dig_b_q[DIGITS-2:0], key_code};
                                    count_q <= count_q + 2'd1;
                                end else begin
                                    reject_q <= 1'b1;
                                end
                            end else if (key_code == KEY_BACK) begin
                                if (count_q != '0) begin
                                    if (state_q == ST_A)
                                        dig_a_q <= {bcd_t'(0), dig_a_q[DIGITS-1:1]};
                                    else
                                        dig_b_q <= {bcd_t'(0), dig_b_q[DIGITS-1:1]};
                                    count_q <= count_q - 2'd1;
                                end else begin
                                    reject_q <= 1'b1;
                                end
                            end else if (key_code == KEY_PLUS && state_q == ST_A
                                         && count_q != '0) begin
                                state_q <= ST_B;
                                dig_b_q <= '0;
                                count_q <= '0;
                            end else if (key_code == KEY_EQ && state_q == ST_B
                                         && count_q != '0) begin
                                sum_q       <= {1'b0, operand_a} + {1'b0, operand_b};
                                sum_valid_q <= 1'b1;
                                state_q     <= ST_RES;
                            end else begin
                                reject_q <= 1'b1;
                            end
                        end
                    end
                    ST_RES: begin
                        if (key_valid) begin
                            // A fresh digit starts a new calculation
                            if (is_digit) begin
                                dig_a_q <= {{(DIGITS-1){bcd_t'(0)}}, key_code};
                                dig_b_q <= '0;
                                sum_q   <= '0;
                                count_q <= 2'd1;
                                state_q <= ST_A;
                            end else begin
                                reject_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_A;
                        dig_a_q <= '0;
                        dig_b_q <= '0;
                        count_q <= '0;
                        sum_q   <= '0;
                    end
                endcase
            end
        end
    end

    bcd_to_bin #(.DIGITS(DIGITS)) u_conv_a (
        .digits_i (dig_a_q),
        .value_o  (operand_a)
    );

    bcd_to_bin #(.DIGITS(DIGITS)) u_conv_b (
        .digits_i (dig_b_q),
        .value_o  (operand_b)
    );

    always_comb begin
        disp_value = '0;
        case (state_q)
            ST_A:    disp_value = {1'b0, operand_a};
            ST_B:    disp_value = {1'b0, operand_b};
            ST_RES:  disp_value = sum_q;
            default: disp_value = '0;
        endcase
    end

    assign sum         = sum_q;
    assign sum_valid   = sum_valid_q;
    assign key_reject  = reject_q;
    assign digit_count = count_q;
    assign state       = state_q;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Directed bench for keypad_operand_entry: key sequences with hand-computed results.
module tb_keypad_operand_entry;

    localparam logic [3:0] K_PLUS = 4'hA;
    localparam logic [3:0] K_EQ   = 4'hB;
    localparam logic [3:0] K_CLR  = 4'hC;
    localparam logic [3:0] K_BACK = 4'hD;
    localparam logic [3:0] K_NONE = 4'hE;

    logic        clk;
    logic        rst;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [9:0]  operand_a;
    logic [9:0]  operand_b;
    logic [10:0] sum;
    logic        sum_valid;
    logic [10:0] disp_value;
    logic [1:0]  state;
    logic [1:0]  digit_count;
    logic        key_reject;

    int compared = 0;
    int mismatched = 0;

    keypad_operand_entry #(.DIGITS(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .sum         (sum),
        .sum_valid   (sum_valid),
        .disp_value  (disp_value),
        .state       (state),
        .digit_count (digit_count),
        .key_reject  (key_reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One-cycle strobe; returns on the negedge after the sampling posedge
    task automatic applyStimulus(input logic [3:0] code);
        @(negedge clk);
        key_code  = code;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic idleCycle();
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b0;
        key_code  = 4'h0;
        key_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_state", 32'(state), 0);
        checkOutput("reset_a", 32'(operand_a), 0);
        checkOutput("reset_sum", 32'(sum), 0);
        checkOutput("reset_count", 32'(digit_count), 0);
        checkOutput("reset_disp", 32'(disp_value), 0);
        rst = 1'b1;

        // 123 + 45 = 168
        applyStimulus(4'd1);
        applyStimulus(4'd2);
        applyStimulus(4'd3);
        checkOutput("t1_a", 32'(operand_a), 123);
        checkOutput("t1_cnt", 32'(digit_count), 3);
        checkOutput("t1_disp_a", 32'(disp_value), 123);
        applyStimulus(K_PLUS);
        checkOutput("t1_state_b", 32'(state), 1);
        checkOutput("t1_cnt_b", 32'(digit_count), 0);
        applyStimulus(K_PLUS);
        checkOutput("t1_plus_in_b_rej", 32'(key_reject), 1);
        applyStimulus(4'd4);
        applyStimulus(4'd5);
        checkOutput("t1_b", 32'(operand_b), 45);
        checkOutput("t1_disp_b", 32'(disp_value), 45);
        applyStimulus(K_EQ);
        checkOutput("t1_sum", 32'(sum), 168);
        checkOutput("t1_sum_valid", 32'(sum_valid), 1);
        checkOutput("t1_state_res", 32'(state), 2);
        checkOutput("t1_disp_sum", 32'(disp_value), 168);
        idleCycle();
        checkOutput("t1_sum_valid_drop", 32'(sum_valid), 0);
        checkOutput("t1_sum_hold", 32'(sum), 168);

        // 999 + 999 with overflow rejection of the fourth digit
        applyStimulus(K_CLR);
        checkOutput("t2_clr_state", 32'(state), 0);
        checkOutput("t2_clr_sum", 32'(sum), 0);
        checkOutput("t2_clr_rej", 32'(key_reject), 0);
        for (int i = 0; i < 3; i++) applyStimulus(4'd9);
        checkOutput("t2_no_rej", 32'(key_reject), 0);
        applyStimulus(4'd9);
        checkOutput("t2_rej", 32'(key_reject), 1);
        checkOutput("t2_a", 32'(operand_a), 999);
        checkOutput("t2_cnt", 32'(digit_count), 3);
        applyStimulus(K_PLUS);
        for (int i = 0; i < 3; i++) applyStimulus(4'd9);
        applyStimulus(K_EQ);
        checkOutput("t2_sum", 32'(sum), 1998);
        checkOutput("t2_sum_valid", 32'(sum_valid), 1);

        // Backspace down to empty, then one too many
        applyStimulus(K_CLR);
        applyStimulus(4'd4);
        applyStimulus(4'd7);
        checkOutput("t3_a47", 32'(operand_a), 47);
        applyStimulus(K_BACK);
        checkOutput("t3_a4", 32'(operand_a), 4);
        checkOutput("t3_back_no_rej", 32'(key_reject), 0);
        applyStimulus(K_BACK);
        checkOutput("t3_a0", 32'(operand_a), 0);
        checkOutput("t3_cnt0", 32'(digit_count), 0);
        applyStimulus(K_BACK);
        checkOutput("t3_back_rej", 32'(key_reject), 1);
        checkOutput("t3_cnt_still0", 32'(digit_count), 0);

        // Illegal keys from a clean start
        applyStimulus(K_CLR);
        applyStimulus(K_PLUS);
        checkOutput("t4_plus_rej", 32'(key_reject), 1);
        applyStimulus(K_EQ);
        checkOutput("t4_eq_rej", 32'(key_reject), 1);
        applyStimulus(K_NONE);
        checkOutput("t4_unused_rej", 32'(key_reject), 1);
        checkOutput("t4_state", 32'(state), 0);
        checkOutput("t4_a", 32'(operand_a), 0);
        checkOutput("t4_sum", 32'(sum), 0);
        checkOutput("t4_disp", 32'(disp_value), 0);
        idleCycle();
        checkOutput("t4_rej_drop", 32'(key_reject), 0);

        // Leading zeros count as digits
        applyStimulus(4'd0);
        applyStimulus(4'd0);
        applyStimulus(4'd7);
        checkOutput("t4_lead_a", 32'(operand_a), 7);
        checkOutput("t4_lead_cnt", 32'(digit_count), 3);

        // Digit after a result starts over
        applyStimulus(K_CLR);
        applyStimulus(4'd5);
        applyStimulus(K_PLUS);
        applyStimulus(4'd6);
        applyStimulus(K_EQ);
        checkOutput("t5_sum", 32'(sum), 11);
        applyStimulus(4'd2);
        checkOutput("t5_state", 32'(state), 0);
        checkOutput("t5_a", 32'(operand_a), 2);
        checkOutput("t5_b", 32'(operand_b), 0);
        checkOutput("t5_sum_clr", 32'(sum), 0);
        checkOutput("t5_disp", 32'(disp_value), 2);
        checkOutput("t5_cnt", 32'(digit_count), 1);
        checkOutput("t5_no_rej", 32'(key_reject), 0);

        // Asynchronous reset in the middle of entry
        applyStimulus(K_CLR);
        applyStimulus(4'd8);
        applyStimulus(K_PLUS);
        applyStimulus(4'd3);
        checkOutput("t6_pre_b", 32'(operand_b), 3);
        #2 rst = 1'b0;
        #1;
        checkOutput("t6_async_a", 32'(operand_a), 0);
        checkOutput("t6_async_b", 32'(operand_b), 0);
        checkOutput("t6_async_state", 32'(state), 0);
        checkOutput("t6_async_disp", 32'(disp_value), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(4'd1);
        checkOutput("t6_after_a", 32'(operand_a), 1);
        checkOutput("t6_after_state", 32'(state), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
